// File: rtl/io_timer.sv
// ---------------------------------------------------------------------------
// io_timer : memory-mapped 16-bit interval timer on the I/O bus window
//            addr[7:5]==2. Software programs a prescaler, a 16-bit compare
//            value and a mode, then polls STATUS or takes the level interrupt
//            raised on every compare match.
//
// Ports
//   clk        core clock
//   reset      asynchronous, active-high reset
//   io_addr    register index (addr[4:1])
//   io_write   one-cycle write strobe (already qualified for this window)
//   io_read    one-cycle read strobe (read side effects only)
//   io_wdata   write byte
//   io_rdata   read data, combinational from io_addr and register state
//   interrupt  level request = pend & ie, driven from flops only
//
// Register map (io_addr)
//   0 CTRL  {5'b0, ie, rl, en}     1 STATUS {7'b0, pend} (write 1 clears)
//   2 PRESCALE (PW bits)           3 CMP_LO  4 CMP_HI
//   5 CNT_LO                       6 CNT_HI  7..15 read 0, writes ignored
//
// Configuration macro: TIMER_LATCH_EN
//   defined   : a CNT_LO read latches cnt[15:8] into a shadow byte that
//               CNT_HI returns, so a LO-then-HI read pair is coherent.
//   undefined : no shadow; CNT_HI returns the live cnt[15:8].
// ---------------------------------------------------------------------------
module io_timer #(
  parameter int PW = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] io_addr,
  input  logic       io_write,
  input  logic       io_read,
  input  logic [7:0] io_wdata,
  output logic [7:0] io_rdata,
  output logic       interrupt
);

  localparam logic [3:0] REG_CTRL   = 4'd0;
  localparam logic [3:0] REG_STATUS = 4'd1;
  localparam logic [3:0] REG_PRESC  = 4'd2;
  localparam logic [3:0] REG_CMP_LO = 4'd3;
  localparam logic [3:0] REG_CMP_HI = 4'd4;
  localparam logic [3:0] REG_CNT_LO = 4'd5;
  localparam logic [3:0] REG_CNT_HI = 4'd6;

  logic [2:0]    ctrl_r;     // {ie, rl, en}
  logic          pend_r;
  logic [PW-1:0] presc_r;
  logic [PW-1:0] psc_r;
  logic [15:0]   cmp_r;
  logic [15:0]   cnt_r;

  logic          tick_s;
  logic          match_s;
  logic          wr_ctrl_s;
  logic          wr_status_s;
  logic          wr_presc_s;
  logic          wr_cmp_lo_s;
  logic          wr_cmp_hi_s;
  logic          wr_cnt_lo_s;
  logic          wr_cnt_hi_s;
  logic [7:0]    presc_rd_s;
  logic [7:0]    cnt_hi_rd_s;

  // Write decode, prescaler tick and compare match.
  always_comb begin
    wr_ctrl_s   = io_write && (io_addr == REG_CTRL);
    wr_status_s = io_write && (io_addr == REG_STATUS);
    wr_presc_s  = io_write && (io_addr == REG_PRESC);
    wr_cmp_lo_s = io_write && (io_addr == REG_CMP_LO);
    wr_cmp_hi_s = io_write && (io_addr == REG_CMP_HI);
    wr_cnt_lo_s = io_write && (io_addr == REG_CNT_LO);
    wr_cnt_hi_s = io_write && (io_addr == REG_CNT_HI);
    tick_s      = ctrl_r[0] && (psc_r == presc_r);
    // Match uses the pre-write counter even when a byte write lands this cycle.
    match_s     = tick_s && (cnt_r == cmp_r);
  end

  // CTRL register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_r <= 3'b000;
    end else if (wr_ctrl_s) begin
      ctrl_r <= io_wdata[2:0];
    end
  end

  // Pending flag: a new match wins over a same-cycle software clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_r <= 1'b0;
    end else if (match_s) begin
      pend_r <= 1'b1;
    end else if (wr_status_s && io_wdata[0]) begin
      pend_r <= 1'b0;
    end
  end

  // PRESCALE register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_r <= '0;
    end else if (wr_presc_s) begin
      presc_r <= io_wdata[PW-1:0];
    end
  end

  // Prescaler counter: held at 0 while disabled or when PRESCALE is rewritten.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psc_r <= '0;
    end else if (!ctrl_r[0] || wr_presc_s) begin
      psc_r <= '0;
    end else if (psc_r == presc_r) begin
      psc_r <= '0;
    end else begin
      psc_r <= psc_r + PW'(1);
    end
  end

  // Compare value; a new byte is used from the following cycle onward.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmp_r <= 16'hFFFF;
    end else if (wr_cmp_lo_s) begin
      cmp_r[7:0] <= io_wdata;
    end else if (wr_cmp_hi_s) begin
      cmp_r[15:8] <= io_wdata;
    end
  end

  // Main counter: software byte writes take priority over increment/reload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= 16'h0000;
    end else if (wr_cnt_lo_s) begin
      cnt_r[7:0] <= io_wdata;
    end else if (wr_cnt_hi_s) begin
      cnt_r[15:8] <= io_wdata;
    end else if (tick_s) begin
      if (match_s && ctrl_r[1]) begin
        cnt_r <= 16'h0000;
      end else begin
        cnt_r <= cnt_r + 16'd1;
      end
    end
  end

`ifdef TIMER_LATCH_EN
  logic [7:0] shadow_r;

  // Shadow of the high byte, captured by a CNT_LO read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_r <= 8'h00;
    end else if (io_read && (io_addr == REG_CNT_LO)) begin
      shadow_r <= cnt_r[15:8];
    end
  end

  // CNT_HI read source: the latched byte.
  always_comb begin
    cnt_hi_rd_s = shadow_r;
  end
`else
  // Read strobe only matters for the shadow latch, absent in this build.
  logic unused_read;
  assign unused_read = io_read;

  // CNT_HI read source: the live high byte.
  always_comb begin
    cnt_hi_rd_s = cnt_r[15:8];
  end
`endif

  // Zero-extend PRESCALE to a full byte for readback.
  always_comb begin
    presc_rd_s           = 8'h00;
    presc_rd_s[PW-1:0]   = presc_r;
  end

  // Read data mux.
  always_comb begin
    case (io_addr)
      REG_CTRL:   io_rdata = {5'b00000, ctrl_r};
      REG_STATUS: io_rdata = {7'b0000000, pend_r};
      REG_PRESC:  io_rdata = presc_rd_s;
      REG_CMP_LO: io_rdata = cmp_r[7:0];
      REG_CMP_HI: io_rdata = cmp_r[15:8];
      REG_CNT_LO: io_rdata = cnt_r[7:0];
      REG_CNT_HI: io_rdata = cnt_hi_rd_s;
      default:    io_rdata = 8'h00;
    endcase
  end

  assign interrupt = pend_r & ctrl_r[2];

endmodule

// File: doc/io_timer.md
# io_timer

Memory-mapped 16-bit interval timer on the I/O bus at `addr[7:5]==2`, alongside the qspi (0) and uart (1) register windows. It sources the core's `interrupt` input into `execute`, which is currently tied to 0. Software programs a prescaler, a compare value and a mode, then polls or takes an interrupt on each compare match.

## Interface
Parameters:
- `PW`, 8: prescaler width in bits; 1..8.

Ports:
- `clk`  in  1: core clock.
- `reset`  in  1: asynchronous, active-high reset.
- `io_addr`  in  4: register index, equal to `addr[4:1]`.
- `io_write`  in  1: one-cycle write strobe, already qualified by `io_access && addr[7:5]==2`.
- `io_read`  in  1: one-cycle read strobe, already qualified the same way. Used only for read side effects.
- `io_wdata`  in  8: write byte.
- `io_rdata`  out  8: read data. Combinational from `io_addr` and register state.
- `interrupt`  out  1: level interrupt request. Equals `pend & ctrl[2]`, driven from flops only.

## Operation
Register map, indexed by `io_addr`:
- 0 CTRL: read/write.
  - bit0 `en`: counting enabled.
  - bit1 `rl`: auto-reload.
  - bit2 `ie`: interrupt enable.
  - bits 7:3 read as 0.
- 1 STATUS:
  - bit0 reads `pend`.
  - Writing 1 to bit0 clears `pend`; writing 0 has no effect.
- 2 PRESCALE: read/write, `PW` bits. Upper bits read as 0.
- 3 CMP_LO, 4 CMP_HI: 16-bit compare value, read/write.
- 5 CNT_LO:
  - Read returns `cnt[7:0]` and, as a side effect, copies `cnt[15:8]` into `shadow`.
  - Write replaces `cnt[7:0]`.
- 6 CNT_HI: read returns `shadow` (see Configuration). Write replaces `cnt[15:8]`.
- 7..15: read 0; writes ignored.

Prescaler:
- `psc` counts 0..PRESCALE while `en=1`.
- `tick` is asserted for one cycle when `psc==PRESCALE` and `en=1`; `psc` then wraps to 0.
- `psc` is forced to 0 whenever `en=0`, and on any PRESCALE write.

Counter, on `tick`:
- If `cnt==cmp`: set `pend`. Then `cnt <= rl ? 0 : cnt+1`.
- Otherwise: `cnt <= cnt+1`. Arithmetic is modulo 2^16, so 0xFFFF wraps to 0.

Resulting behaviour:
- With `rl=1`, the match period is (cmp+1)*(PRESCALE+1) clocks.
- With `rl=0`, the counter is free-running and matches once every 65536 ticks.

Simultaneous events:
- A counter byte write in the same cycle as `tick` takes priority over the increment and over the reload. The match check still uses the pre-write `cnt` and can still set `pend`.
- A STATUS clear in the same cycle as a new match leaves `pend=1`; set wins.
- A CMP byte write takes effect for comparisons from the next cycle onward.
- Clearing `en` freezes `cnt` and `pend`; `psc` is forced to 0.

## Timing
Reset values:
- `ctrl=0`, `pend=0`, `psc=0`, PRESCALE=0, `cmp=16'hFFFF`, `cnt=0`, `shadow=0`.
- `interrupt=0`.
- `io_rdata` reflects the addressed register immediately; for example, CMP_LO reads 8'hFF after reset.

Latencies:
- A register write is visible on `io_rdata` in the cycle after `io_write`.
- After a write of `en=1` at cycle t, with PRESCALE=P, the first `tick` occurs at cycle t+1+P.
- `pend` is set in the clock edge that ends the matching `tick` cycle.
- `interrupt` rises in the cycle after that `tick` cycle, provided `ie=1`.
- `interrupt` falls in the cycle after a STATUS clear, or after a write of `ie=0`.

Handshake:
- Reads and writes complete in one cycle. The top level ties `io_rdone` and `io_wdone` to 1, and the block never stalls.
- `io_read` and `io_write` are never asserted together.

Reset mid-operation asynchronously returns every flop to its reset value. No tick or match is generated in the cycle that reset deasserts.

## Configuration
`TIMER_LATCH_EN`:
- Defined: a CNT_LO read loads `shadow` with `cnt[15:8]`, and CNT_HI returns `shadow`. Reading LO then HI gives a coherent 16-bit value.
- Undefined:
  - `shadow` is not implemented.
  - CNT_HI returns the live `cnt[15:8]`.
  - `io_read` is unused.
  - A LO/HI read pair may tear across a carry.

## Test plan
- Reset, then read all registers -> CTRL=0, STATUS=0, PRESCALE=0, CMP_LO=CMP_HI=8'hFF, CNT=0, indices 7..15 read 0, `interrupt=0`.
- PRESCALE=3, CMP=16'h0004, CTRL=3'b111 -> `interrupt` first rises 20 clocks after the first tick window opens. After a STATUS write of 1, `interrupt` drops next cycle and re-rises exactly 20 clocks after the previous rise.
- CTRL=3'b001 (no reload, no ie), PRESCALE=0, CNT=16'hFFFE, CMP=16'h0001 -> `cnt` goes FFFF, 0000, 0001, then `pend=1` on the next tick, `cnt=0002`, and `interrupt` stays 0.
- Force a STATUS clear in the same cycle as a match -> `pend` reads 1 afterwards. Write CNT_LO in the same cycle as a tick -> the written value holds with no increment.
- With `TIMER_LATCH_EN`, `cnt=16'h00FF`, read CNT_LO, let one tick occur, then read CNT_HI -> 8'hFF then 8'h00. Without the macro -> 8'hFF then 8'h01.
- Assert `reset` while running with `pend=1` -> `interrupt` goes to 0 asynchronously and all registers return to their reset values.
